// File: rtl/fast_control_seq_pkg.sv
// Shared constants and types for the fast-control generator.
// Holds the bit positions in the fast-control word and the calibration sequencer states.
package fast_control_pkg;

  // Bit positions within the fast-control word
  localparam int unsigned FC_BCR          = 0;
  localparam int unsigned FC_L1A          = 1;
  localparam int unsigned FC_LINK_RESET   = 2;
  localparam int unsigned FC_BUFFER_CLEAR = 3;
  localparam int unsigned FC_STATIC0      = 4;
  localparam int unsigned FC_CALIB        = 5;
  localparam int unsigned FC_STATIC_HI    = 6;

  // Calibration sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    FIRE  = 2'd3
  } calib_state_e;

endpackage

// File: rtl/fast_control_seq_if.sv
// Control and status bundle between the register front-end and the fast-control generator.
// Every signal is synchronous to clk_bx.
// The request inputs (l1a_req, link_reset_req, buffer_clear_req, calib_req) are
// single-cycle strobes. There is no valid/ready backpressure: the generator takes
// a strobe on the edge where it is high and never stalls the producer. Status
// outputs are registered and valid on every cycle.
interface fast_control_seq_if #(
  parameter int NUM_CMD   = 8,
  parameter int ORB_W     = 12,
  parameter int CAL_OFS_W = 8,
  parameter int CAL_LEN_W = 4,
  parameter int PER_W     = 16
);
  logic [ORB_W-1:0]     orb_length;
  logic                 l1a_req;
  logic                 link_reset_req;
  logic                 buffer_clear_req;
  logic                 calib_req;
  logic [CAL_LEN_W-1:0] calib_len;
  logic [CAL_OFS_W-1:0] calib_offset;
  logic                 periodic_en;
  logic [PER_W-1:0]     periodic_period;
  logic [7:0]           l1a_holdoff;
  logic                 sync_en;
  logic [ORB_W-1:0]     sync_bx;
  logic [NUM_CMD-6:0]   static_bits;
  logic [2*NUM_CMD-1:0] fc_stream_enc;
  logic [ORB_W-1:0]     bx_count;
  logic [31:0]          l1a_count;
  logic [15:0]          l1a_dropped;
  logic                 calib_busy;

  modport master (
    output orb_length, l1a_req, link_reset_req, buffer_clear_req, calib_req,
           calib_len, calib_offset, periodic_en, periodic_period, l1a_holdoff,
           sync_en, sync_bx, static_bits,
    input  fc_stream_enc, bx_count, l1a_count, l1a_dropped, calib_busy
  );

  modport slave (
    input  orb_length, l1a_req, link_reset_req, buffer_clear_req, calib_req,
           calib_len, calib_offset, periodic_en, periodic_period, l1a_holdoff,
           sync_en, sync_bx, static_bits,
    output fc_stream_enc, bx_count, l1a_count, l1a_dropped, calib_busy
  );
endinterface

// File: rtl/fc_calib_seq.sv
// Calibration sequencer.
// Raises the CALIB pulse for max(calib_len,1) BX, then fires one L1A candidate
// calib_offset BX after the pulse started. An offset of 0 means no L1A is fired.
module fc_calib_seq
  import fast_control_pkg::*;
#(
  parameter int CAL_OFS_W = 8,
  parameter int CAL_LEN_W = 4
) (
  input  logic                 clk_bx,
  input  logic                 reset,
  input  logic                 calib_req,
  input  logic [CAL_LEN_W-1:0] calib_len,
  input  logic [CAL_OFS_W-1:0] calib_offset,
  output logic                 calib_pulse,
  output logic                 calib_fire,
  output calib_state_e         state_o
);
  calib_state_e         state_q, state_d;
  logic [CAL_LEN_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CAL_OFS_W-1:0] ofs_cnt_q, ofs_cnt_d;

  // State and counter registers
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      ofs_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      ofs_cnt_q   <= ofs_cnt_d;
    end
  end

  // Next state, counters and pulse/fire outputs. The offset counter runs in parallel
  // with the pulse counter, so FIRE can preempt the tail of a long pulse.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    ofs_cnt_d   = ofs_cnt_q;
    calib_pulse = 1'b0;
    calib_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (calib_req) begin
          state_d     = PULSE;
          pulse_cnt_d = (calib_len == '0) ? CAL_LEN_W'(1) : calib_len;
          ofs_cnt_d   = calib_offset;
        end
      end
      PULSE: begin
        calib_pulse = (pulse_cnt_q != '0);
        if (pulse_cnt_q != '0) pulse_cnt_d = pulse_cnt_q - CAL_LEN_W'(1);
        if (ofs_cnt_q != '0) ofs_cnt_d = ofs_cnt_q - CAL_OFS_W'(1);
        if (ofs_cnt_q == CAL_OFS_W'(1)) state_d = FIRE;
        else if (pulse_cnt_q <= CAL_LEN_W'(1)) state_d = (ofs_cnt_q == '0) ? IDLE : WAIT;
      end
      WAIT: begin
        if (ofs_cnt_q != '0) ofs_cnt_d = ofs_cnt_q - CAL_OFS_W'(1);
        if (ofs_cnt_q == CAL_OFS_W'(1)) state_d = FIRE;
        else if (ofs_cnt_q == '0) state_d = IDLE;
      end
      FIRE: begin
        calib_fire  = 1'b1;
        state_d     = IDLE;
        pulse_cnt_d = '0;
        ofs_cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
endmodule

// File: rtl/hamming84_enc.sv
// Hamming(8,4) SECDED encoder for one nibble.
// Byte layout: bit j holds codeword position j+1. Parity bits sit at positions 1, 2 and 4,
// data bits d0..d3 sit at positions 3, 5, 6 and 7, and bit 7 is overall even parity.
module hamming84_enc (
  input  logic [3:0] data_i,
  output logic [7:0] code_o
);
  logic       p1;
  logic       p2;
  logic       p4;
  logic [6:0] c7;

  // Compute the three Hamming parities, then add overall parity on top
  always_comb begin
    p1     = data_i[0] ^ data_i[1] ^ data_i[3];
    p2     = data_i[0] ^ data_i[2] ^ data_i[3];
    p4     = data_i[1] ^ data_i[2] ^ data_i[3];
    c7     = {data_i[3], data_i[2], data_i[1], p4, data_i[0], p2, p1};
    code_o = {^c7, c7};
  end
endmodule

// File: rtl/fast_control_seq.sv
// Fast-control generator for the pflink fabric, entirely in the clk_bx domain.
// Builds one command word per BX (BCR, L1A, link reset, buffer clear, calib, static bits)
// and drives it Hamming(8,4)-encoded. A request sampled at t appears in the word at t+1
// and on fc_stream_enc at t+2.
module fast_control_seq
  import fast_control_pkg::*;
#(
  parameter int NUM_CMD   = 8,
  parameter int ORB_W     = 12,
  parameter int CAL_OFS_W = 8,
  parameter int CAL_LEN_W = 4,
  parameter int PER_W     = 16
) (
  input  logic              clk_bx,
  input  logic              reset,
  fast_control_seq_if.slave bus
);
  logic [ORB_W-1:0]     bx_count_q, bx_count_d;
  logic [ORB_W:0]       bx_inc;
  logic [PER_W-1:0]     per_cnt_q, per_cnt_d, per_last;
  logic                 per_tick;
  logic [7:0]           holdoff_q, holdoff_d;
  logic [31:0]          l1a_count_q, l1a_count_d;
  logic [15:0]          l1a_dropped_q, l1a_dropped_d;
  logic                 l1a_cand, l1a_issue;
  logic                 lr_pend_q, lr_pend_d, bc_pend_q, bc_pend_d;
  logic                 lr_fire, bc_fire;
  logic [NUM_CMD-1:0]   fc_word_q, fc_word_d;
  logic [2*NUM_CMD-1:0] fc_stream_enc_q, fc_stream_enc_d;
  logic                 calib_pulse, calib_fire;
  calib_state_e         calib_state;

  fc_calib_seq #(
    .CAL_OFS_W (CAL_OFS_W),
    .CAL_LEN_W (CAL_LEN_W)
  ) u_calib (
    .clk_bx       (clk_bx),
    .reset        (reset),
    .calib_req    (bus.calib_req),
    .calib_len    (bus.calib_len),
    .calib_offset (bus.calib_offset),
    .calib_pulse  (calib_pulse),
    .calib_fire   (calib_fire),
    .state_o      (calib_state)
  );

  // All sequential state of the generator
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      bx_count_q      <= '0;
      per_cnt_q       <= '0;
      holdoff_q       <= '0;
      l1a_count_q     <= '0;
      l1a_dropped_q   <= '0;
      lr_pend_q       <= 1'b0;
      bc_pend_q       <= 1'b0;
      fc_word_q       <= '0;
      fc_stream_enc_q <= '0;
    end else begin
      bx_count_q      <= bx_count_d;
      per_cnt_q       <= per_cnt_d;
      holdoff_q       <= holdoff_d;
      l1a_count_q     <= l1a_count_d;
      l1a_dropped_q   <= l1a_dropped_d;
      lr_pend_q       <= lr_pend_d;
      bc_pend_q       <= bc_pend_d;
      fc_word_q       <= fc_word_d;
      fc_stream_enc_q <= fc_stream_enc_d;
    end
  end

  // Orbit counter (>= so a shortened orbit wraps at once) and periodic L1A tick
  always_comb begin
    bx_inc     = {1'b0, bx_count_q} + (ORB_W+1)'(1);
    bx_count_d = (bx_inc >= {1'b0, bus.orb_length}) ? '0 : bx_inc[ORB_W-1:0];
    per_last   = (bus.periodic_period == '0) ? '0 : bus.periodic_period - PER_W'(1);
    per_tick   = bus.periodic_en && (per_cnt_q == per_last);
    per_cnt_d  = (!bus.periodic_en || per_tick) ? '0 : per_cnt_q + PER_W'(1);
  end

  // L1A arbitration: merge candidates, apply holdoff, count issued and dropped
  always_comb begin
    l1a_cand      = bus.l1a_req | per_tick | calib_fire;
    l1a_issue     = l1a_cand && (holdoff_q == '0);
    holdoff_d     = holdoff_q;
    l1a_count_d   = l1a_count_q;
    l1a_dropped_d = l1a_dropped_q;
    if (l1a_issue) begin
      holdoff_d   = bus.l1a_holdoff;
      l1a_count_d = l1a_count_q + 32'd1;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 8'd1;
    end
    if (l1a_cand && (holdoff_q != '0) && (l1a_dropped_q != 16'hFFFF))
      l1a_dropped_d = l1a_dropped_q + 16'd1;
  end

  // Link reset / buffer clear: immediate, or held pending until the sync BX slot
  always_comb begin
    lr_fire   = bus.sync_en ? (lr_pend_q && (bx_count_q == bus.sync_bx))
                            : (lr_pend_q || bus.link_reset_req);
    bc_fire   = bus.sync_en ? (bc_pend_q && (bx_count_q == bus.sync_bx))
                            : (bc_pend_q || bus.buffer_clear_req);
    lr_pend_d = (lr_pend_q || bus.link_reset_req) && !lr_fire;
    bc_pend_d = (bc_pend_q || bus.buffer_clear_req) && !bc_fire;
  end

  // Assemble the next command word
  always_comb begin
    fc_word_d                           = '0;
    fc_word_d[FC_BCR]                   = (bx_count_q == '0);
    fc_word_d[FC_L1A]                   = l1a_issue;
    fc_word_d[FC_LINK_RESET]            = lr_fire;
    fc_word_d[FC_BUFFER_CLEAR]          = bc_fire;
    fc_word_d[FC_STATIC0]               = bus.static_bits[0];
    fc_word_d[FC_CALIB]                 = calib_pulse;
    fc_word_d[NUM_CMD-1:FC_STATIC_HI]   = bus.static_bits[NUM_CMD-6:1];
  end

  // One encoder per nibble: nibble k of the word becomes byte k of the stream
  for (genvar k = 0; k < NUM_CMD/4; k++) begin : g_enc
    hamming84_enc u_enc (
      .data_i (fc_word_q[4*k +: 4]),
      .code_o (fc_stream_enc_d[8*k +: 8])
    );
  end

  assign bus.fc_stream_enc = fc_stream_enc_q;
  assign bus.bx_count      = bx_count_q;
  assign bus.l1a_count     = l1a_count_q;
  assign bus.l1a_dropped   = l1a_dropped_q;
  assign bus.calib_busy    = (calib_state != IDLE);
endmodule

// File: tb/tb_fast_control_seq.sv
// Bench for fast_control_seq: directed stimulus pushes expected command events
// (cycle, command bits) into a queue; a negedge monitor decodes the stream and
// pops/compares every command it sees.
module tb_fast_control_seq;
  localparam int NUM_CMD = 8;
  localparam int EW      = 36;
  localparam logic [3:0] CMD_L1A = 4'b0001;
  localparam logic [3:0] CMD_LR  = 4'b0010;
  localparam logic [3:0] CMD_BC  = 4'b0100;
  localparam logic [3:0] CMD_CAL = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk_bx = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_bx = ~clk_bx;

  int cyc = 0;
  always @(posedge clk_bx) cyc <= cyc + 1;

  fast_control_seq_if #(.NUM_CMD(NUM_CMD)) bus ();

  fast_control_seq #(.NUM_CMD(NUM_CMD)) dut (
    .clk_bx (clk_bx),
    .reset  (reset),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            bcr_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            base     = 0;
  int            chk_from = 0;
  logic          chk_en   = 1'b0;
  logic          bcr_en   = 1'b0;
  logic [2:0]    static_val = 3'b101;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Reference Hamming(8,4): byte bit j is codeword position j+1, parities at 1,2,4
  function automatic logic [7:0] ham_enc(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos & p) != 0) && (pos != p)) par ^= c[pos-1];
      c[p-1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk_bx) begin
    logic [NUM_CMD-1:0] w;
    logic [3:0]         cmd;
    logic [EW-1:0]      ev;
    for (int k = 0; k < NUM_CMD/4; k++) begin
      logic [7:0] b;
      b = bus.fc_stream_enc[8*k +: 8];
      w[4*k +: 4] = {b[6], b[5], b[4], b[2]};
      check("hamming_byte", {56'd0, b}, {56'd0, ham_enc(w[4*k +: 4])});
    end
    if (chk_en && !reset && cyc >= chk_from)
      check("static_bits", {61'd0, w[7:6], w[4]}, {61'd0, static_val});
    cmd = {w[5], w[3], w[2], w[1]};
    if (cmd != 4'h0) begin
      if (exp_q.size() == 0) check("unexpected_cmd", {60'd0, cmd}, 64'd0);
      else begin
        ev = exp_q.pop_front();
        check("cmd_event", {28'd0, cyc, cmd}, {28'd0, ev});
      end
    end
    if (bcr_en && w[0]) begin
      if (bcr_q.size() == 0) check("unexpected_bcr", 64'(cyc), 64'd0);
      else check("bcr_cycle", 64'(cyc), 64'(bcr_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_bx); #1;
    end
  endtask

  task automatic expect_cmd(input int c, input logic [3:0] cmd);
    exp_q.push_back({c[31:0], cmd});
  endtask

  // One-cycle strobe of the selected requests: {calib, buffer_clear, link_reset, l1a}
  task automatic pulse_req(input logic [3:0] m);
    bus.l1a_req          = m[0];
    bus.link_reset_req   = m[1];
    bus.buffer_clear_req = m[2];
    bus.calib_req        = m[3];
    @(posedge clk_bx); #1;
    bus.l1a_req          = 1'b0;
    bus.link_reset_req   = 1'b0;
    bus.buffer_clear_req = 1'b0;
    bus.calib_req        = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    chk_en = 1'b0;
    @(posedge clk_bx); #1;
    check("rst_stream", 64'(bus.fc_stream_enc), 64'd0);
    check("rst_bx_count", 64'(bus.bx_count), 64'd0);
    check("rst_l1a_count", 64'(bus.l1a_count), 64'd0);
    check("rst_l1a_dropped", 64'(bus.l1a_dropped), 64'd0);
    check("rst_calib_busy", 64'(bus.calib_busy), 64'd0);
    repeat (2) begin @(posedge clk_bx); #1; end
    reset    = 1'b0;
    base     = cyc;
    chk_from = cyc + 2;
    chk_en   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    bus.orb_length       = 12'd45;
    bus.l1a_req          = 1'b0;
    bus.link_reset_req   = 1'b0;
    bus.buffer_clear_req = 1'b0;
    bus.calib_req        = 1'b0;
    bus.calib_len        = 4'd0;
    bus.calib_offset     = 8'd0;
    bus.periodic_en      = 1'b0;
    bus.periodic_period  = 16'd0;
    bus.l1a_holdoff      = 8'd0;
    bus.sync_en          = 1'b0;
    bus.sync_bx          = 12'd0;
    bus.static_bits      = 3'b101;

    // Orbit: 45 BX, then shorten to 10 at bx 30
    do_reset();
    bcr_q.push_back(base + 2);
    bcr_q.push_back(base + 47);
    bcr_q.push_back(base + 78);
    bcr_q.push_back(base + 88);
    bcr_q.push_back(base + 98);
    bcr_en = 1'b1;
    wait_cyc(base + 44); check("bx_44", 64'(bus.bx_count), 64'd44);
    wait_cyc(base + 45); check("bx_wrap45", 64'(bus.bx_count), 64'd0);
    wait_cyc(base + 75); check("bx_30", 64'(bus.bx_count), 64'd30);
    bus.orb_length = 12'd10;
    wait_cyc(base + 76); check("bx_short_wrap", 64'(bus.bx_count), 64'd0);
    wait_cyc(base + 77); check("bx_after_wrap", 64'(bus.bx_count), 64'd1);
    wait_cyc(base + 101);
    bcr_en = 1'b0;
    check("bcr_all_seen", 64'(bcr_q.size()), 64'd0);
    bus.orb_length = 12'd45;

    // Software L1A with holdoff 5: second request 3 BX later is dropped
    do_reset();
    bus.l1a_holdoff = 8'd5;
    wait_cyc(base + 10);
    expect_cmd(cyc + 2, CMD_L1A);
    pulse_req(CMD_L1A);
    wait_cyc(base + 13);
    pulse_req(CMD_L1A);
    wait_cyc(base + 20);
    check("l1a_count_1", 64'(bus.l1a_count), 64'd1);
    check("l1a_dropped_1", 64'(bus.l1a_dropped), 64'd1);
    wait_cyc(base + 30);
    expect_cmd(cyc + 2, CMD_L1A);
    pulse_req(CMD_L1A);
    wait_cyc(base + 40);
    check("l1a_count_2", 64'(bus.l1a_count), 64'd2);
    // Software request and periodic tick in the same BX: one L1A, no drop
    wait_cyc(base + 50);
    bus.periodic_period = 16'd0;
    bus.periodic_en     = 1'b1;
    expect_cmd(cyc + 2, CMD_L1A);
    pulse_req(CMD_L1A);
    bus.periodic_en = 1'b0;
    wait_cyc(base + 60);
    check("l1a_count_3", 64'(bus.l1a_count), 64'd3);
    check("l1a_dropped_same", 64'(bus.l1a_dropped), 64'd1);
    bus.l1a_holdoff = 8'd0;

    // Periodic L1A: period 100 for 1000 BX, then period 0 for 8 BX
    do_reset();
    wait_cyc(base + 5);
    n0 = cyc;
    bus.periodic_period = 16'd100;
    bus.periodic_en     = 1'b1;
    for (int j = 0; j < 10; j++) expect_cmd(n0 + 101 + 100*j, CMD_L1A);
    wait_cyc(n0 + 1000);
    bus.periodic_en = 1'b0;
    wait_cyc(n0 + 1010);
    check("periodic_count_10", 64'(bus.l1a_count), 64'd10);
    n0 = cyc;
    bus.periodic_period = 16'd0;
    bus.periodic_en     = 1'b1;
    for (int j = 0; j < 8; j++) expect_cmd(n0 + 2 + j, CMD_L1A);
    wait_cyc(n0 + 8);
    bus.periodic_en = 1'b0;
    wait_cyc(n0 + 15);
    check("periodic0_count_18", 64'(bus.l1a_count), 64'd18);

    // Calibration: len 2, offset 20, second request mid-sequence ignored
    do_reset();
    wait_cyc(base + 10);
    n0 = cyc;
    bus.calib_len    = 4'd2;
    bus.calib_offset = 8'd20;
    check("calib_busy_idle", 64'(bus.calib_busy), 64'd0);
    expect_cmd(n0 + 3, CMD_CAL);
    expect_cmd(n0 + 4, CMD_CAL);
    expect_cmd(n0 + 23, CMD_L1A);
    pulse_req(CMD_CAL);
    check("calib_busy_start", 64'(bus.calib_busy), 64'd1);
    wait_cyc(n0 + 5);
    pulse_req(CMD_CAL);
    wait_cyc(n0 + 21); check("calib_busy_fire", 64'(bus.calib_busy), 64'd1);
    wait_cyc(n0 + 22); check("calib_busy_done", 64'(bus.calib_busy), 64'd0);
    wait_cyc(n0 + 30); check("calib_l1a_count", 64'(bus.l1a_count), 64'd1);
    // Offset 0: pulse only, no L1A
    wait_cyc(base + 50);
    n0 = cyc;
    bus.calib_len    = 4'd3;
    bus.calib_offset = 8'd0;
    expect_cmd(n0 + 3, CMD_CAL);
    expect_cmd(n0 + 4, CMD_CAL);
    expect_cmd(n0 + 5, CMD_CAL);
    pulse_req(CMD_CAL);
    wait_cyc(n0 + 3); check("calib0_busy", 64'(bus.calib_busy), 64'd1);
    wait_cyc(n0 + 4); check("calib0_idle", 64'(bus.calib_busy), 64'd0);
    wait_cyc(n0 + 30); check("calib0_no_l1a", 64'(bus.l1a_count), 64'd1);

    // Sync-aligned link reset / buffer clear (orbit 45, sync_bx 7)
    do_reset();
    bus.sync_en = 1'b1;
    bus.sync_bx = 12'd7;
    wait_cyc(base + 20);
    expect_cmd(base + 54, CMD_LR | CMD_BC);
    pulse_req(CMD_LR | CMD_BC);
    wait_cyc(base + 30);
    pulse_req(CMD_LR);
    wait_cyc(base + 60);
    pulse_req(CMD_LR);
    wait_cyc(base + 65);
    expect_cmd(cyc + 2, CMD_LR);
    bus.sync_en = 1'b0;
    // Unreachable sync slot: held until sync_en drops
    wait_cyc(base + 110);
    bus.sync_en = 1'b1;
    bus.sync_bx = 12'd50;
    wait_cyc(base + 112);
    pulse_req(CMD_BC);
    wait_cyc(base + 200);
    expect_cmd(cyc + 2, CMD_BC);
    bus.sync_en = 1'b0;
    wait_cyc(base + 210);
    check("sync_events_done", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a calib sequence with a pending link reset
    do_reset();
    bus.sync_en = 1'b1;
    bus.sync_bx = 12'd7;
    wait_cyc(base + 20);
    pulse_req(CMD_LR);
    wait_cyc(base + 22);
    bus.calib_len    = 4'd4;
    bus.calib_offset = 8'd30;
    for (int j = 0; j < 4; j++) expect_cmd(base + 25 + j, CMD_CAL);
    pulse_req(CMD_CAL);
    wait_cyc(base + 40);
    check("pre_reset_busy", 64'(bus.calib_busy), 64'd1);
    do_reset();
    wait_cyc(base + 150);
    check("post_reset_l1a", 64'(bus.l1a_count), 64'd0);
    check("post_reset_busy", 64'(bus.calib_busy), 64'd0);
    bus.sync_en = 1'b0;

    check("all_events_seen", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
